// File: rtl/fp16_dot_sequencer_if.sv
// Bundles the host job port, operand stream, MAC hookup and result port of fp16_dot_sequencer.
// The sequencer connects through the slave modport; the master modport is the surrounding system.
interface fp16_dot_sequencer_if #(
   parameter int LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             busy;

   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_a;
   logic [15:0]      in_b;

   logic [15:0]      mac_a;
   logic [15:0]      mac_b;
   logic             mac_rst_n;
   logic [15:0]      mac_result;

   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_data;

   modport master (
      output start, len, in_valid, in_a, in_b, mac_result, out_ready,
      input  busy, in_ready, mac_a, mac_b, mac_rst_n, out_valid, out_data
   );

   modport slave (
      input  start, len, in_valid, in_a, in_b, mac_result, out_ready,
      output busy, in_ready, mac_a, mac_b, mac_rst_n, out_valid, out_data
   );
endinterface

// File: rtl/fp16_dot_sequencer.sv
// Job-level controller: clears the FP16 MAC, streams len operand pairs into it,
// waits MAC_LAT cycles for the pipeline to drain, then presents the accumulated result.
module fp16_dot_sequencer #(
   parameter int LEN_W   = 8,
   parameter int MAC_LAT = 3
) (
   input  logic                clk,
   input  logic                reset,
   fp16_dot_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   // The drain counter is two bits wide, so it counts 0..MAC_LAT-1 (MAC_LAT up to 4).
   localparam logic [1:0] DRAIN_LAST = 2'(MAC_LAT - 1);

   state_t           state_q;
   state_t           state_d;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] elem_cnt_q;
   logic [1:0]       drain_cnt_q;
   logic             mac_rst_n_q;
   logic [15:0]      out_data_q;

   logic accept;
   logic last_elem;
   logic drain_done;

   assign accept     = (state_q == STREAM) && bus.in_valid;
   assign last_elem  = (elem_cnt_q == len_q - LEN_W'(1));
   assign drain_done = (drain_cnt_q == DRAIN_LAST);

   // NOTE: every variable driven here gets its default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = CLEAR;
         CLEAR:   state_d = (len_q == '0) ? DRAIN : STREAM;
         STREAM:  if (accept && last_elem) state_d = DRAIN;
         DRAIN:   if (drain_done) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         len_q       <= '0;
         elem_cnt_q  <= '0;
         drain_cnt_q <= '0;
         mac_rst_n_q <= 1'b0;
         out_data_q  <= 16'h0000;
      end else begin
         state_q     <= state_d;
         mac_rst_n_q <= (state_d != CLEAR);

         if (state_q == IDLE && bus.start) begin
            len_q      <= bus.len;
            elem_cnt_q <= '0;
         end else if (accept) begin
            elem_cnt_q <= elem_cnt_q + LEN_W'(1);
         end

         if (state_q == DRAIN) begin
            drain_cnt_q <= drain_cnt_q + 2'd1;
         end else begin
            drain_cnt_q <= '0;
         end

         // The MAC result reflects the last pair exactly at the end of the final drain cycle.
         if (state_q == DRAIN && drain_done) begin
            out_data_q <= bus.mac_result;
         end
      end
   end

   // Bubbles feed +0 x +0 so the MAC, which has no enable, keeps its accumulator unchanged.
   assign bus.mac_a     = accept ? bus.in_a : 16'h0000;
   assign bus.mac_b     = accept ? bus.in_b : 16'h0000;
   assign bus.mac_rst_n = mac_rst_n_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.in_ready  = (state_q == STREAM);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_fp16_dot_sequencer.sv
// Directed bench for fp16_dot_sequencer with a behavioural 3-stage FP16 MAC model
// (exact-value real arithmetic, synchronous clear on mac_rst_n) behind the sequencer.
module tb_fp16_dot_sequencer;
   localparam int LEN_W   = 8;
   localparam int MAC_LAT = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   fp16_dot_sequencer_if #(.LEN_W(LEN_W)) bus ();

   fp16_dot_sequencer #(
      .LEN_W  (LEN_W),
      .MAC_LAT(MAC_LAT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int edge_cnt = 0;
   int s_edge   = 0;
   int e_edge   = 0;
   int d_edge   = 0;

   logic [15:0] va [0:7];
   logic [15:0] vb [0:7];

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // ---------------- FP16 helpers (normal numbers only) ----------------
   function automatic real h2r(input logic [15:0] h);
      int  e;
      real v;
      e = int'(h[14:10]);
      if (e == 0) return 0.0;
      v = 1.0 + real'(h[9:0]) / 1024.0;
      while (e > 15) begin v = v * 2.0; e--; end
      while (e < 15) begin v = v / 2.0; e++; end
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] r2h(input real x);
      int   e;
      int   m;
      logic s;
      real  v;
      if (x == 0.0) return 16'h0000;
      s = (x < 0.0);
      v = s ? -x : x;
      e = 15;
      while (v >= 2.0) begin v = v / 2.0; e++; end
      while (v < 1.0) begin v = v * 2.0; e--; end
      m = int'((v - 1.0) * 1024.0);
      return {s, e[4:0], m[9:0]};
   endfunction

   // ---------------- MAC model: A/B sampled at edge E, result valid after edge E+2 ----------------
   real p1  = 0.0;
   real p2  = 0.0;
   real acc = 0.0;

   always @(posedge clk) begin
      if (!bus.mac_rst_n) begin
         p1  <= 0.0;
         p2  <= 0.0;
         acc <= 0.0;
      end else begin
         p1  <= h2r(bus.mac_a) * h2r(bus.mac_b);
         p2  <= p1;
         acc <= acc + p2;
      end
   end

   always_comb bus.mac_result = r2h(acc);

   // ---------------- monitors for mac_rst_n low cycles and in_ready cycles ----------------
   logic mon_en = 1'b0;
   int   rst_low_cnt;
   int   ready_cnt;

   always @(negedge clk) begin
      if (!mon_en) begin
         rst_low_cnt <= 0;
         ready_cnt   <= 0;
      end else begin
         if (!bus.mac_rst_n) rst_low_cnt <= rst_low_cnt + 1;
         if (bus.in_ready)   ready_cnt   <= ready_cnt + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic [LEN_W-1:0] n);
      bus.len   = n;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      s_edge    = edge_cnt;
   endtask

   // Presents n pairs from va/vb; gap idle cycles after each pair, checking gated MAC inputs.
   task automatic feed(input int n, input int gap);
      int guard;
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_a     = va[i];
         bus.in_b     = vb[i];
         #1;
         guard = 0;
         while (!bus.in_ready && guard < 20) begin
            tick();
            guard++;
         end
         check("in_ready_timeout", {15'd0, bus.in_ready}, 16'd1);
         check("pass_a", bus.mac_a, va[i]);
         check("pass_b", bus.mac_b, vb[i]);
         tick();
         e_edge       = edge_cnt;
         bus.in_valid = 1'b0;
         bus.in_a     = 16'h5555;
         bus.in_b     = 16'hAAAA;
         for (int g = 0; g < gap; g++) begin
            #1;
            check("bubble_a", bus.mac_a, 16'h0000);
            check("bubble_b", bus.mac_b, 16'h0000);
            tick();
         end
      end
   endtask

   task automatic wait_result;
      int guard;
      guard = 0;
      while (!bus.out_valid && guard < 40) begin
         tick();
         guard++;
      end
      d_edge = edge_cnt;
      check("out_valid_timeout", {15'd0, bus.out_valid}, 16'd1);
   endtask

   task automatic take_result;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("out_valid_drop", {15'd0, bus.out_valid}, 16'd0);
      check("idle_after_take", {15'd0, bus.busy}, 16'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.in_valid  = 1'b0;
      bus.in_a      = 16'h0000;
      bus.in_b      = 16'h0000;
      bus.out_ready = 1'b0;

      // Power-on reset values
      repeat (3) tick();
      check("por_busy", {15'd0, bus.busy}, 16'd0);
      check("por_in_ready", {15'd0, bus.in_ready}, 16'd0);
      check("por_out_valid", {15'd0, bus.out_valid}, 16'd0);
      check("por_out_data", bus.out_data, 16'h0000);
      check("por_mac_rst_n", {15'd0, bus.mac_rst_n}, 16'd0);
      reset = 1'b0;
      tick();
      check("mac_rst_n_release", {15'd0, bus.mac_rst_n}, 16'd1);

      // Reset mid-STREAM: len=5, two pairs accepted, then reset for 3 cycles
      va[0] = 16'h3C00; vb[0] = 16'h4000;
      va[1] = 16'h3C00; vb[1] = 16'h4000;
      start_job(8'd5);
      feed(2, 0);
      check("mid_stream_busy", {15'd0, bus.busy}, 16'd1);
      reset = 1'b1;
      repeat (3) tick();
      check("rst_busy", {15'd0, bus.busy}, 16'd0);
      check("rst_in_ready", {15'd0, bus.in_ready}, 16'd0);
      check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
      check("rst_out_data", bus.out_data, 16'h0000);
      check("rst_mac_a", bus.mac_a, 16'h0000);
      check("rst_mac_b", bus.mac_b, 16'h0000);
      check("rst_mac_rst_n", {15'd0, bus.mac_rst_n}, 16'd0);
      reset = 1'b0;
      tick();
      va[0] = 16'h3C00; vb[0] = 16'h3C00;
      start_job(8'd1);
      feed(1, 0);
      wait_result();
      check("post_reset_result", bus.out_data, 16'h3C00);
      take_result();

      // Full-rate job: 1*2 + 1*2 + 2*2 = 8.0
      va[0] = 16'h3C00; vb[0] = 16'h4000;
      va[1] = 16'h3C00; vb[1] = 16'h4000;
      va[2] = 16'h4000; vb[2] = 16'h4000;
      start_job(8'd3);
      feed(3, 0);
      wait_result();
      check("full_rate_result", bus.out_data, 16'h4800);
      check("last_accept_to_valid", 16'(d_edge - e_edge), 16'd3);
      check("start_to_valid", 16'(d_edge - s_edge), 16'd7);
      take_result();

      // Back-to-back: accumulator must be cleared, 3.0 not 11.0
      va[0] = 16'h4200; vb[0] = 16'h3C00;
      mon_en = 1'b1;
      start_job(8'd1);
      feed(1, 0);
      wait_result();
      mon_en = 1'b0;
      check("b2b_result", bus.out_data, 16'h4200);
      check("mac_rst_n_low_cycles", 16'(rst_low_cnt), 16'd1);

      // Output back-pressure with start pulsed while DONE
      for (int i = 0; i < 10; i++) begin
         bus.start = (i == 3);
         bus.len   = 8'd2;
         #1;
         check("bp_out_valid", {15'd0, bus.out_valid}, 16'd1);
         check("bp_out_data", bus.out_data, 16'h4200);
         tick();
      end
      bus.start = 1'b0;
      take_result();
      tick();
      check("start_not_queued", {15'd0, bus.busy}, 16'd0);

      // Bubbles: two idle cycles after each pair
      va[0] = 16'h3C00; vb[0] = 16'h4000;
      va[1] = 16'h3C00; vb[1] = 16'h4000;
      va[2] = 16'h4000; vb[2] = 16'h4000;
      start_job(8'd3);
      feed(3, 2);
      wait_result();
      check("bubble_result", bus.out_data, 16'h4800);
      take_result();

      // Zero length: CLEAR then MAC_LAT drain cycles, never ready
      mon_en = 1'b1;
      start_job(8'd0);
      wait_result();
      mon_en = 1'b0;
      check("zero_len_result", bus.out_data, 16'h0000);
      check("zero_len_latency", 16'(d_edge - s_edge), 16'(1 + MAC_LAT));
      check("zero_len_no_ready", 16'(ready_cnt), 16'd0);
      take_result();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
